gen3_tx_frame_scheduler: RTL and testbench

GEN3_TX_FRAME_SCHEDULER -- requirements
Module: gen3_tx_frame_scheduler

---
 rtl/gen3_tx_frame_scheduler.sv | 131 +++++++++++++
 tb/tb_gen3_tx_frame_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen3_tx_frame_scheduler.sv
// Gen3 transmit frame scheduler: arbitrates TLPs and DLLPs onto a 32-bit
// framed stream (STP/SDP tokens, IDL fill) with 4-DW block marking.
module gen3_tx_frame_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlp_req,
  input  logic [10:0] tlp_len_dw,
  input  logic [11:0] tlp_seq,
  input  logic [31:0] tlp_data,
  output logic        tlp_ack,
  input  logic        dllp_req,
  input  logic [47:0] dllp_data,
  output logic        dllp_ack,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_block_start,
  output logic [1:0]  out_sync_header,
  output logic        len_err
);

  // State names the word currently held in the output register.
  typedef enum logic [2:0] {IDLE, STP, TLP_DATA, SDP, DLLP_TAIL} state_t;
  typedef enum logic {GRANT_TLP, GRANT_DLLP} grant_t;

  state_t      state, state_nxt;
  grant_t      last_grant, last_grant_nxt;
  logic [10:0] dw_left, dw_left_nxt;
  logic [10:0] flen;
  logic [1:0]  blk_cnt;
  logic [31:0] word_nxt;
  logic        len_short, len_err_nxt;
  logic        advance, arb_point;
  logic        grant_tlp, grant_dllp;

  assign advance = !out_valid || out_ready;

  // Arbitration: single requester wins; on a tie the source not served last wins.
  always_comb begin
    len_short  = tlp_len_dw < 11'd5;
    flen       = len_short ? 11'd5 : tlp_len_dw;
    arb_point  = (state == IDLE) || (state == DLLP_TAIL) ||
                 ((state == TLP_DATA) && (dw_left == '0));
    grant_tlp  = 1'b0;
    grant_dllp = 1'b0;
    if (tlp_req && dllp_req) begin
      grant_tlp  = (last_grant == GRANT_DLLP);
      grant_dllp = (last_grant == GRANT_TLP);
    end else begin
      grant_tlp  = tlp_req;
      grant_dllp = dllp_req;
    end
  end

  // Next-state, next output word and the combinational consume handshakes.
  // Acks are combinational so the source sees "consumed at this edge" and can
  // present its next DW for the following edge; they are masked during reset.
  always_comb begin
    state_nxt      = state;
    dw_left_nxt    = dw_left;
    last_grant_nxt = last_grant;
    len_err_nxt    = len_err;
    word_nxt       = out_data;
    tlp_ack        = 1'b0;
    dllp_ack       = 1'b0;
    if (advance && !rst) begin
      if (arb_point) begin
        if (grant_tlp) begin
          state_nxt      = STP;
          word_nxt       = {4'h0, tlp_seq, ^flen, flen[10:4], flen[3:0], 4'hF};
          dw_left_nxt    = flen - 11'd1;
          last_grant_nxt = GRANT_TLP;
          if (len_short) len_err_nxt = 1'b1;
        end else if (grant_dllp) begin
          state_nxt      = SDP;
          word_nxt       = {dllp_data[15:0], 8'hAC, 8'hF0};
          last_grant_nxt = GRANT_DLLP;
        end else begin
          state_nxt = IDLE;
          word_nxt  = '0;
        end
      end else begin
        case (state)
          STP, TLP_DATA: begin
            state_nxt   = TLP_DATA;
            word_nxt    = tlp_data;
            tlp_ack     = 1'b1;
            dw_left_nxt = dw_left - 11'd1;
          end
          SDP: begin
            state_nxt = DLLP_TAIL;
            word_nxt  = dllp_data[47:16];
            dllp_ack  = 1'b1;
          end
          default: begin
            state_nxt = IDLE;
            word_nxt  = '0;
          end
        endcase
      end
    end
  end

  // Registered state and output stage; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= GRANT_DLLP;
      dw_left         <= '0;
      blk_cnt         <= '0;
      len_err         <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_block_start <= 1'b0;
      out_sync_header <= 2'b00;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      dw_left    <= dw_left_nxt;
      len_err    <= len_err_nxt;
      if (advance) begin
        out_valid       <= 1'b1;
        out_data        <= word_nxt;
        out_block_start <= (blk_cnt == 2'd0);
        out_sync_header <= (blk_cnt == 2'd0) ? 2'b10 : 2'b00;
        blk_cnt         <= blk_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_gen3_tx_frame_scheduler.sv
// Self-checking bench for gen3_tx_frame_scheduler: packet-level reference model.
module tb_gen3_tx_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        tlp_req;
  logic [10:0] tlp_len_dw;
  logic [11:0] tlp_seq;
  logic [31:0] tlp_data;
  logic        tlp_ack;
  logic        dllp_req;
  logic [47:0] dllp_data;
  logic        dllp_ack;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_block_start;
  logic [1:0]  out_sync_header;
  logic        len_err;

  always #5 clk = ~clk;

  gen3_tx_frame_scheduler dut (
    .clk(clk), .rst(rst),
    .tlp_req(tlp_req), .tlp_len_dw(tlp_len_dw), .tlp_seq(tlp_seq),
    .tlp_data(tlp_data), .tlp_ack(tlp_ack),
    .dllp_req(dllp_req), .dllp_data(dllp_data), .dllp_ack(dllp_ack),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_block_start(out_block_start), .out_sync_header(out_sync_header),
    .len_err(len_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pending traffic (source side) and expected output stream.
  logic [10:0] tq_len[$];
  logic [11:0] tq_seq[$];
  logic [31:0] tpay[$];
  logic [47:0] dq[$];
  logic [31:0] exp_q[$];
  int          tidx;
  bit          short_seen;

  function automatic int framed(input logic [10:0] l);
    return (l < 11'd5) ? 5 : int'(l);
  endfunction

  function automatic logic [31:0] token(input logic [10:0] l, input logic [11:0] s);
    int f, ones, v;
    f = framed(l);
    ones = 0;
    for (int i = 0; i < 11; i++) ones += (f >> i) & 1;
    v = 15 + (f % 16) * 16 + ((f / 16) % 128) * 256 + (ones % 2) * 32768 + int'(s) * 65536;
    return 32'(v);
  endfunction

  task automatic clear_all();
    tq_len.delete(); tq_seq.delete(); tpay.delete(); dq.delete(); exp_q.delete();
    tidx = 0;
    short_seen = 1'b0;
  endtask

  task automatic add_tlp(input logic [10:0] l, input logic [11:0] s);
    tq_len.push_back(l);
    tq_seq.push_back(s);
    for (int i = 0; i < framed(l) - 1; i++) tpay.push_back($urandom);
    if (l < 11'd5) short_seen = 1'b1;
  endtask

  task automatic add_dllp(input logic [47:0] d);
    dq.push_back(d);
  endtask

  task automatic drive_src();
    tlp_req    = (tq_len.size() > 0);
    tlp_len_dw = tlp_req ? tq_len[0] : 11'd0;
    tlp_seq    = tlp_req ? tq_seq[0] : 12'd0;
    tlp_data   = (tpay.size() > 0) ? tpay[0] : 32'd0;
    dllp_req   = (dq.size() > 0);
    dllp_data  = dllp_req ? dq[0] : 48'd0;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall cycles 4..6
  task automatic run_stream(input int mode, input int extra_idle, input string name);
    int ti, di, pp, got, cyc, limit, n_tack, n_dack, exp_tack, exp_dack, n_exp;
    bit last_dllp, pick_t, t_ack, d_ack, prev_hold, prev_bs;
    logic [31:0] prev_data;
    logic [47:0] dw;
    // Expected stream: round-robin merge of the pending packets, then IDL fill.
    ti = 0; di = 0; pp = 0; last_dllp = 1'b1;
    while (ti < tq_len.size() || di < dq.size()) begin
      if (ti < tq_len.size() && di < dq.size()) pick_t = last_dllp;
      else pick_t = (ti < tq_len.size());
      if (pick_t) begin
        exp_q.push_back(token(tq_len[ti], tq_seq[ti]));
        for (int j = 0; j < framed(tq_len[ti]) - 1; j++) begin
          exp_q.push_back(tpay[pp]);
          pp++;
        end
        ti++;
        last_dllp = 1'b0;
      end else begin
        dw = dq[di];
        exp_q.push_back({dw[15:0], 8'hAC, 8'hF0});
        exp_q.push_back(dw[47:16]);
        di++;
        last_dllp = 1'b1;
      end
    end
    exp_tack = pp;
    exp_dack = dq.size();
    for (int j = 0; j < extra_idle; j++) exp_q.push_back(32'd0);
    n_exp = exp_q.size();
    limit = n_exp * 8 + 50;

    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; drive_src();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got = 0; cyc = 0; n_tack = 0; n_dack = 0; prev_hold = 1'b0;
    prev_data = '0; prev_bs = 1'b0;
    while (got < n_exp && cyc < limit) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 4 && cyc < 7);
      endcase
      drive_src();
      #1;
      if (prev_hold) begin
        n_cmp++;
        if (out_data !== prev_data || out_block_start !== prev_bs) begin
          n_bad++;
          $display("FAIL %s hold: data=%h bs=%b, required data=%h bs=%b", name, out_data, out_block_start, prev_data, prev_bs);
        end
      end
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (tlp_ack !== 1'b0 || dllp_ack !== 1'b0) begin
          n_bad++;
          $display("FAIL %s stall_ack: tlp_ack=%b dllp_ack=%b, required 0 0", name, tlp_ack, dllp_ack);
        end
      end
      if (tlp_ack === 1'b1 && dllp_ack === 1'b1) begin
        n_bad++;
        $display("FAIL %s both_ack: tlp_ack=1 dllp_ack=1, required at most one", name);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== exp_q[got] || out_block_start !== (got % 4 == 0) ||
            out_sync_header !== ((got % 4 == 0) ? 2'b10 : 2'b00)) begin
          n_bad++;
          $display("FAIL %s word%0d: data=%h bs=%b sh=%b, required data=%h bs=%b sh=%b", name, got,
                   out_data, out_block_start, out_sync_header, exp_q[got], (got % 4 == 0),
                   (got % 4 == 0) ? 2'b10 : 2'b00);
        end
        got++;
      end
      t_ack = tlp_ack; d_ack = dllp_ack;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data; prev_bs = out_block_start;
      @(negedge clk);
      cyc++;
      if (t_ack) begin
        n_tack++;
        if (tpay.size() > 0) void'(tpay.pop_front());
        if (tq_len.size() > 0) begin
          tidx++;
          if (tidx == framed(tq_len[0]) - 1) begin
            void'(tq_len.pop_front());
            void'(tq_seq.pop_front());
            tidx = 0;
          end
        end
      end
      if (d_ack) begin
        n_dack++;
        if (dq.size() > 0) void'(dq.pop_front());
      end
    end
    n_cmp++;
    if (got != n_exp) begin
      n_bad++;
      $display("FAIL %s timeout: words=%0d, required %0d", name, got, n_exp);
    end
    n_cmp++;
    if (n_tack != exp_tack || n_dack != exp_dack) begin
      n_bad++;
      $display("FAIL %s ack_count: tlp=%0d dllp=%0d, required tlp=%0d dllp=%0d", name, n_tack, n_dack, exp_tack, exp_dack);
    end
    n_cmp++;
    if (len_err !== short_seen) begin
      n_bad++;
      $display("FAIL %s len_err: %b, required %b", name, len_err, short_seen);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    clear_all();
    add_tlp(11'd8, 12'h055);
    add_dllp(48'h1122_3344_5566);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; drive_src();
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_data, out_block_start, out_sync_header, tlp_ack, dllp_ack, len_err} !== '0) begin
        n_bad++;
        $display("FAIL reset: valid=%b data=%h bs=%b sh=%b tack=%b dack=%b len_err=%b, required all 0",
                 out_valid, out_data, out_block_start, out_sync_header, tlp_ack, dllp_ack, len_err);
      end
    end
    clear_all();
  endtask

  task automatic test_idle();
    clear_all();
    run_stream(0, 12, "idle");
  endtask

  task automatic test_single_tlp();
    clear_all();
    add_tlp(11'd6, 12'h123);
    run_stream(0, 4, "tlp6");
  endtask

  task automatic test_back_to_back();
    clear_all();
    add_tlp(11'd7, 12'h001);
    add_tlp(11'd5, 12'h002);
    add_dllp(48'hB5B4_B3B2_B1B0);
    add_dllp(48'h0102_0304_0506);
    run_stream(0, 4, "tie");
  endtask

  task automatic test_backpressure();
    clear_all();
    add_tlp(11'd10, 12'hABC);
    run_stream(2, 4, "stall");
  endtask

  task automatic test_len_err();
    clear_all();
    add_tlp(11'd3, 12'h777);
    run_stream(0, 8, "short");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_all();
      for (int k = 0; k < int'($urandom_range(0, 4)); k++)
        add_tlp(11'($urandom_range(1, 24)), 12'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 4)); k++)
        add_dllp({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
      run_stream(1, 5, "random");
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    add_tlp(11'd20, 12'h3C3);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; drive_src();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_block_start, out_sync_header, tlp_ack, dllp_ack, len_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: valid=%b data=%h bs=%b sh=%b tack=%b dack=%b, required all 0",
               out_valid, out_data, out_block_start, out_sync_header, tlp_ack, dllp_ack);
    end
    clear_all();
    drive_src();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'd0 || out_block_start !== (k % 4 == 0) ||
          tlp_ack !== 1'b0 || dllp_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_idle%0d: valid=%b data=%h bs=%b tack=%b, required 1 0 %b 0",
                 k, out_valid, out_data, out_block_start, tlp_ack, (k % 4 == 0));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    tlp_req = 1'b0; tlp_len_dw = '0; tlp_seq = '0; tlp_data = '0;
    dllp_req = 1'b0; dllp_data = '0;
    test_reset();
    test_idle();
    test_single_tlp();
    test_back_to_back();
    test_backpressure();
    test_len_err();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
